// File: rtl/dmem_responder.sv
// Data-memory responder: services load/store requests with a fixed LATENCY and holds the pipeline via memStall.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned requests and pulses alignErr.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        readValid,
    output logic        memStall,
    output logic        alignErr
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             is_write_q, is_write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             read_valid_q, read_valid_d;
    logic             align_err_q, align_err_d;

    logic [IDX_W-1:0] addr_idx;
    logic             request;
    logic             misaligned;
    logic             accept;
    logic             enter_resp;
    logic             unused_addr;

    assign addr_idx = address[IDX_W+1:2];
    assign request  = memRead | memWrite;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned  = request && (address[1:0] != 2'b00);
    assign unused_addr = ^address[31:IDX_W+2];
`else
    assign misaligned  = 1'b0;
    assign unused_addr = ^{address[31:IDX_W+2], address[1:0]};
`endif

    // Gated by reset so nothing is accepted or written while reset is held.
    assign accept = rst && (state_q == IDLE) && request && !misaligned;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_write_d   = is_write_q;
        idx_d        = idx_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        align_err_d  = 1'b0;
        enter_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_write_d = memWrite;
                    idx_d      = addr_idx;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (misaligned) begin
                    align_err_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Load data is captured on the edge entering RESP so it is visible during the release cycle.
        if (enter_resp && !is_write_d) begin
            read_data_d  = mem[idx_d];
            read_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            is_write_q   <= 1'b0;
            idx_q        <= '0;
            read_data_q  <= 32'd0;
            read_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_write_q   <= is_write_d;
            idx_q        <= idx_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            align_err_q  <= align_err_d;
        end
    end

    // Storage is never reset; a store commits on the edge that ends its acceptance cycle.
    always_ff @(posedge clk) begin
        if (accept && memWrite) begin
            mem[addr_idx] <= writeData;
        end
    end

    assign memStall  = rst && (accept || (state_q == WAIT));
    assign readData  = read_data_q;
    assign readValid = read_valid_q;
`ifdef DMEM_ALIGN_CHECK_EN
    assign alignErr  = align_err_q;
`else
    assign alignErr  = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=3 instance driven from a vector table,
// plus a LATENCY=1 instance and hand-written reset, held-request and alignment sequences.
module tb_dmem_responder;
    logic        clk;
    logic        rst;

    logic        rd3, wr3;
    logic [31:0] addr3, wd3;
    logic [31:0] rdata3;
    logic        rvalid3, stall3, aerr3;

    logic        rd1, wr1;
    logic [31:0] addr1, wd1;
    logic [31:0] rdata1;
    logic        rvalid1, stall1, aerr1;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .memRead(rd3), .memWrite(wr3), .address(addr3),
        .writeData(wd3), .readData(rdata3), .readValid(rvalid3), .memStall(stall3),
        .alignErr(aerr3)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .memRead(rd1), .memWrite(wr1), .address(addr1),
        .writeData(wd1), .readData(rdata1), .readValid(rvalid1), .memStall(stall1),
        .alignErr(aerr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wd);
        @(posedge clk);
        #1;
        rd3 = rd; wr3 = wr; addr3 = addr; wd3 = wd;
    endtask

    task automatic addVec(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic stall, input logic valid,
                          input logic [31:0] data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd;
        v.exp_stall = stall; v.exp_valid = valid; v.exp_data = data;
        vecs.push_back(v);
    endtask

    // One held LATENCY=3 request: three stall cycles, then the release cycle.
    task automatic addReq(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] prev_data,
                          input logic valid, input logic [31:0] new_data);
        for (int k = 0; k < 3; k++) addVec(rd, wr, addr, wd, 1'b1, 1'b0, prev_data);
        addVec(rd, wr, addr, wd, 1'b0, valid, new_data);
    endtask

    task automatic runRequest(input string name, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] prev_data, input logic valid,
                              input logic [31:0] new_data);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(rd, wr, addr, wd);
            @(negedge clk);
            checkOutput({name, ".stall"}, stall3, (k < 3) ? 1'b1 : 1'b0);
            checkOutput({name, ".valid"}, rvalid3, (k == 3) ? valid : 1'b0);
            checkOutput({name, ".data"}, rdata3, (k == 3) ? new_data : prev_data);
            checkOutput({name, ".alignErr"}, aerr3, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int valid_count;

        rst = 1'b0;
        rd3 = 1'b0; wr3 = 1'b0; addr3 = 32'h0; wd3 = 32'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wd1 = 32'h0;

        addReq(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        addReq(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        addVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
        addReq(1'b0, 1'b1, 32'h1004, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        addReq(1'b1, 1'b0, 32'h0004, 32'h0, 32'hDEADBEEF, 1'b1, 32'hA5A5A5A5);
        addVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5);
        addReq(1'b1, 1'b1, 32'h20, 32'h11112222, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5);
        addReq(1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b1, 32'h11112222);
        addVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h11112222);

        @(negedge clk);
        checkOutput("reset.stall", stall3, 1'b0);
        checkOutput("reset.valid", rvalid3, 1'b0);
        checkOutput("reset.data", rdata3, 32'h0);
        checkOutput("reset.alignErr", aerr3, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.stall", i), stall3, vecs[i].exp_stall);
            checkOutput($sformatf("vec%0d.valid", i), rvalid3, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d.data", i), rdata3, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d.alignErr", i), aerr3, 1'b0);
        end

        // Held load: the RESP cycle must not re-accept, giving a 4-cycle period.
        valid_count = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("held%0d.stall", i), stall3, (i % 4 != 3) ? 1'b1 : 1'b0);
            checkOutput($sformatf("held%0d.data", i), rdata3,
                        (i < 3) ? 32'h11112222 : 32'hDEADBEEF);
            if (rvalid3) valid_count++;
        end
        checkOutput("held.validCount", 32'(valid_count), 32'd3);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // LATENCY=1 instance: store then load of word 0.
        @(posedge clk); #1 wr1 = 1'b1; addr1 = 32'h0; wd1 = 32'h12345678;
        @(negedge clk); checkOutput("lat1.st0.stall", stall1, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); checkOutput("lat1.st1.stall", stall1, 1'b0);
        checkOutput("lat1.st1.valid", rvalid1, 1'b0);
        @(posedge clk); #1 wr1 = 1'b0; rd1 = 1'b1;
        @(negedge clk); checkOutput("lat1.ld0.stall", stall1, 1'b1);
        checkOutput("lat1.ld0.valid", rvalid1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); checkOutput("lat1.ld1.stall", stall1, 1'b0);
        checkOutput("lat1.ld1.valid", rvalid1, 1'b1);
        checkOutput("lat1.ld1.data", rdata1, 32'h12345678);
        @(posedge clk); #1 rd1 = 1'b0;
        @(negedge clk); checkOutput("lat1.ld2.valid", rvalid1, 1'b0);
        checkOutput("lat1.ld2.data", rdata1, 32'h12345678);

        // Reset in cycle 1 of a load drops it and clears the outputs at once.
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk); checkOutput("rstld.c0.stall", stall3, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        checkOutput("rstld.stall", stall3, 1'b0);
        checkOutput("rstld.valid", rvalid3, 1'b0);
        checkOutput("rstld.data", rdata3, 32'h0);
        checkOutput("rstld.alignErr", aerr3, 1'b0);
        @(posedge clk); #1 rst = 1'b1; rd3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rstld.after%0d.stall", i), stall3, 1'b0);
            checkOutput($sformatf("rstld.after%0d.valid", i), rvalid3, 1'b0);
            @(posedge clk); #1;
        end

        // A store accepted before reset stays committed.
        applyStimulus(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
        @(negedge clk); checkOutput("rstst.c0.stall", stall3, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        #1 checkOutput("rstst.stall", stall3, 1'b0);
        @(posedge clk); #1 rst = 1'b1; wr3 = 1'b0;
        runRequest("rstst.load", 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D);

`ifdef DMEM_ALIGN_CHECK_EN
        applyStimulus(1'b0, 1'b1, 32'h13, 32'hBAD0BAD0);
        @(negedge clk);
        checkOutput("align.stall", stall3, 1'b0);
        checkOutput("align.errSame", aerr3, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("align.errNext", aerr3, 1'b1);
        checkOutput("align.stallNext", stall3, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("align.errCleared", aerr3, 1'b0);
        runRequest("align.load", 1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 32'hDEADBEEF);
`else
        runRequest("trunc.store", 1'b0, 1'b1, 32'h13, 32'hBAD0BAD0, 32'hCAFEF00D, 1'b0,
                   32'hCAFEF00D);
        runRequest("trunc.load", 1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 32'hBAD0BAD0);
`endif

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
